// File: rtl/mem_wb_pkg.sv
// Shared widths, op codes, control encodings and payload types for the MEM->WB stage.
package mem_wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG64_W    = 64;
    localparam int unsigned ALUOP_W    = 8;
    localparam int unsigned STALL_W    = 6;
    localparam int unsigned STALL_MEM  = 4;
    localparam int unsigned STALL_WB   = 5;

    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = REG_ADDR_W'(0);
    localparam logic [REG_W-1:0]      ZERO_WORD     = REG_W'(0);
    localparam logic                  WRITE_ENABLE  = 1'b1;
    localparam logic                  WRITE_DISABLE = 1'b0;

    typedef logic [ALUOP_W-1:0] aluop_t;

    localparam aluop_t EXE_NOP_OP  = 8'h00;
    localparam aluop_t EXE_ADD_OP  = 8'h20;
    localparam aluop_t EXE_LIDT_OP = 8'h70;
    localparam aluop_t EXE_LGDT_OP = 8'h71;
    localparam aluop_t EXE_LLDT_OP = 8'h72;
    localparam aluop_t EXE_LTR_OP  = 8'h73;
    localparam aluop_t EXE_SIDT_OP = 8'h74;
    localparam aluop_t EXE_SGDT_OP = 8'h75;
    localparam aluop_t EXE_SLDT_OP = 8'h76;
    localparam aluop_t EXE_STR_OP  = 8'h77;

    typedef enum logic [2:0] {
        BANK_NONE,
        BANK_IDT,
        BANK_GDT,
        BANK_LDT,
        BANK_TR
    } bank_sel_e;

    typedef enum logic [1:0] {
        ACT_CAPTURE,
        ACT_BUBBLE,
        ACT_HOLD
    } pipe_act_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [REG_W-1:0]      wdata;
    } wb_gpr_t;

    localparam wb_gpr_t WB_BUBBLE = '{wd: NOP_REG_ADDR, wreg: WRITE_DISABLE, wdata: ZERO_WORD};

    // Only the load-descriptor ops select a bank entry; stores and everything else map to none.
    function automatic bank_sel_e bank_sel(input aluop_t op);
        bank_sel_e sel;
        sel = BANK_NONE;
        case (op)
            EXE_LIDT_OP: sel = BANK_IDT;
            EXE_LGDT_OP: sel = BANK_GDT;
            EXE_LLDT_OP: sel = BANK_LDT;
            EXE_LTR_OP:  sel = BANK_TR;
            default:     sel = BANK_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mem_wb_sysreg_bank.sv
// Four 64-bit system-descriptor registers; at most one entry written per commit, chosen by aluop.
module mem_wb_sysreg_bank
    import mem_wb_pkg::*;
#(
    parameter logic [REG64_W-1:0] IDT_RST = 64'h0,
    parameter logic [REG64_W-1:0] GDT_RST = 64'h0,
    parameter logic [REG64_W-1:0] LDT_RST = 64'h0,
    parameter logic [REG64_W-1:0] TR_RST  = 64'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               commit_en,
    input  aluop_t             aluop,
    input  logic [REG64_W-1:0] idt_in,
    input  logic [REG64_W-1:0] gdt_in,
    input  logic [REG64_W-1:0] ldt_in,
    input  logic [REG64_W-1:0] tr_in,
    output logic [REG64_W-1:0] idt,
    output logic [REG64_W-1:0] gdt,
    output logic [REG64_W-1:0] ldt,
    output logic [REG64_W-1:0] tr,
    output logic               hit_c
);

    bank_sel_e          sel_c;
    logic [REG64_W-1:0] idt_nxt;
    logic [REG64_W-1:0] gdt_nxt;
    logic [REG64_W-1:0] ldt_nxt;
    logic [REG64_W-1:0] tr_nxt;

    // Write-select decode; hit_c tells the pipeline register a commit actually landed.
    always_comb begin
        sel_c   = bank_sel(aluop);
        hit_c   = 1'b0;
        idt_nxt = idt;
        gdt_nxt = gdt;
        ldt_nxt = ldt;
        tr_nxt  = tr;
        if (commit_en) begin
            case (sel_c)
                BANK_IDT: begin idt_nxt = idt_in; hit_c = 1'b1; end
                BANK_GDT: begin gdt_nxt = gdt_in; hit_c = 1'b1; end
                BANK_LDT: begin ldt_nxt = ldt_in; hit_c = 1'b1; end
                BANK_TR:  begin tr_nxt  = tr_in;  hit_c = 1'b1; end
                default:  hit_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idt <= IDT_RST;
            gdt <= GDT_RST;
            ldt <= LDT_RST;
            tr  <= TR_RST;
        end else begin
            idt <= idt_nxt;
            gdt <= gdt_nxt;
            ldt <= ldt_nxt;
            tr  <= tr_nxt;
        end
    end

endmodule

// File: rtl/mem_wb.sv
// MEM->WB pipeline register with stall/flush/bubble priority, plus the descriptor register bank.
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter logic [REG64_W-1:0] IDT_RST = 64'h0,
    parameter logic [REG64_W-1:0] GDT_RST = 64'h0,
    parameter logic [REG64_W-1:0] LDT_RST = 64'h0,
    parameter logic [REG64_W-1:0] TR_RST  = 64'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [REG_W-1:0]      mem_wdata,
    input  aluop_t                mem_aluop,
    input  logic                  mem_w_reg64,
    input  logic [REG64_W-1:0]    mem_idt,
    input  logic [REG64_W-1:0]    mem_gdt,
    input  logic [REG64_W-1:0]    mem_ldt,
    input  logic [REG64_W-1:0]    mem_tr,
    input  logic                  mem_exp_fl,
    output logic [REG_ADDR_W-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [REG_W-1:0]      wb_wdata,
    output logic                  wb_w_reg64,
    output logic [REG64_W-1:0]    idt_o,
    output logic [REG64_W-1:0]    gdt_o,
    output logic [REG64_W-1:0]    ldt_o,
    output logic [REG64_W-1:0]    tr_o
);

    pipe_act_e act_c;
    logic      commit_c;
    logic      bank_hit_c;
    wb_gpr_t   gpr_q;
    wb_gpr_t   gpr_nxt;
    logic      w64_nxt;

    // Flush beats any stall; a faulting op that would otherwise be captured becomes a bubble.
    always_comb begin
        act_c = ACT_CAPTURE;
        if (flush) begin
            act_c = ACT_BUBBLE;
        end else if (stall[STALL_MEM] && !stall[STALL_WB]) begin
            act_c = ACT_BUBBLE;
        end else if (stall[STALL_MEM]) begin
            act_c = ACT_HOLD;
        end else if (mem_exp_fl) begin
            act_c = ACT_BUBBLE;
        end
    end

    assign commit_c = (act_c == ACT_CAPTURE) && mem_w_reg64;

    mem_wb_sysreg_bank #(
        .IDT_RST (IDT_RST),
        .GDT_RST (GDT_RST),
        .LDT_RST (LDT_RST),
        .TR_RST  (TR_RST)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .commit_en (commit_c),
        .aluop     (mem_aluop),
        .idt_in    (mem_idt),
        .gdt_in    (mem_gdt),
        .ldt_in    (mem_ldt),
        .tr_in     (mem_tr),
        .idt       (idt_o),
        .gdt       (gdt_o),
        .ldt       (ldt_o),
        .tr        (tr_o),
        .hit_c     (bank_hit_c)
    );

    // The commit pulse is never re-asserted while holding, so a held slot cannot commit twice.
    always_comb begin
        gpr_nxt = gpr_q;
        w64_nxt = 1'b0;
        case (act_c)
            ACT_BUBBLE: gpr_nxt = WB_BUBBLE;
            ACT_HOLD:   gpr_nxt = gpr_q;
            default: begin
                gpr_nxt = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata};
                w64_nxt = bank_hit_c;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpr_q      <= WB_BUBBLE;
            wb_w_reg64 <= 1'b0;
        end else begin
            gpr_q      <= gpr_nxt;
            wb_w_reg64 <= w64_nxt;
        end
    end

    assign wb_wd    = gpr_q.wd;
    assign wb_wreg  = gpr_q.wreg;
    assign wb_wdata = gpr_q.wdata;

endmodule

// File: tb/tb_mem_wb.sv
// Directed-vector bench for mem_wb: stimulus queues expected post-edge outputs, a monitor compares.
module tb_mem_wb;
    import mem_wb_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic        mem_w_reg64;
    logic [63:0] mem_idt, mem_gdt, mem_ldt, mem_tr;
    logic        mem_exp_fl;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_w_reg64;
    logic [63:0] idt_o, gdt_o, ldt_o, tr_o;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        w64;
        logic [63:0] idt, gdt, ldt, tr;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    localparam logic [63:0] G1 = 64'h0000_1000_0000_00FF;
    localparam logic [63:0] I1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] L1 = 64'h5555_6666_7777_8888;
    localparam logic [63:0] T1 = 64'h9999_AAAA_BBBB_CCCC;
    localparam logic [63:0] T2 = 64'hDEAD_0000_BEEF_0001;
    localparam logic [63:0] T3 = 64'h0123_4567_89AB_CDEF;

    mem_wb dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .mem_wd      (mem_wd),
        .mem_wreg    (mem_wreg),
        .mem_wdata   (mem_wdata),
        .mem_aluop   (mem_aluop),
        .mem_w_reg64 (mem_w_reg64),
        .mem_idt     (mem_idt),
        .mem_gdt     (mem_gdt),
        .mem_ldt     (mem_ldt),
        .mem_tr      (mem_tr),
        .mem_exp_fl  (mem_exp_fl),
        .wb_wd       (wb_wd),
        .wb_wreg     (wb_wreg),
        .wb_wdata    (wb_wdata),
        .wb_w_reg64  (wb_w_reg64),
        .idt_o       (idt_o),
        .gdt_o       (gdt_o),
        .ldt_o       (ldt_o),
        .tr_o        (tr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s: got %h expected %h", tag, field, act, req);
        end
    endtask

    // Monitor: outputs are registered, so each queued expectation is checked just after its edge.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                chk(n, "wb_wd",      64'(wb_wd),      64'(e.wd));
                chk(n, "wb_wreg",    64'(wb_wreg),    64'(e.wreg));
                chk(n, "wb_wdata",   64'(wb_wdata),   64'(e.wdata));
                chk(n, "wb_w_reg64", 64'(wb_w_reg64), 64'(e.w64));
                chk(n, "idt_o",      idt_o,           e.idt);
                chk(n, "gdt_o",      gdt_o,           e.gdt);
                chk(n, "ldt_o",      ldt_o,           e.ldt);
                chk(n, "tr_o",       tr_o,            e.tr);
            end
        end
    end

    task automatic vec(
        input string       tag,
        input logic [5:0]  st,
        input logic        fl,
        input logic        ex,
        input logic [7:0]  op,
        input logic        w64,
        input logic [4:0]  wd,
        input logic        wreg,
        input logic [31:0] wdata,
        input logic [4:0]  e_wd,
        input logic        e_wreg,
        input logic [31:0] e_wdata,
        input logic        e_w64,
        input logic [63:0] e_idt,
        input logic [63:0] e_gdt,
        input logic [63:0] e_ldt,
        input logic [63:0] e_tr
    );
        exp_t e;
        stall       = st;
        flush       = fl;
        mem_exp_fl  = ex;
        mem_aluop   = op;
        mem_w_reg64 = w64;
        mem_wd      = wd;
        mem_wreg    = wreg;
        mem_wdata   = wdata;
        e.wd = e_wd; e.wreg = e_wreg; e.wdata = e_wdata; e.w64 = e_w64;
        e.idt = e_idt; e.gdt = e_gdt; e.ldt = e_ldt; e.tr = e_tr;
        exp_q.push_back(e);
        name_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        mem_idt = I1; mem_gdt = G1; mem_ldt = L1; mem_tr = T1;
        stall = '0; flush = 1'b0; mem_exp_fl = 1'b0;
        mem_aluop = EXE_NOP_OP; mem_w_reg64 = 1'b0;
        mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0;

        // Reset wins even with a committable LIDT presented.
        vec("rst1", 6'b000000, 0, 0, EXE_LIDT_OP, 1, 5'd5, 1, 32'h1, 5'd0, 0, 32'h0, 0, 64'h0, 64'h0, 64'h0, 64'h0);
        vec("rst2", 6'b000000, 0, 0, EXE_LIDT_OP, 1, 5'd5, 1, 32'h1, 5'd0, 0, 32'h0, 0, 64'h0, 64'h0, 64'h0, 64'h0);
        rst = 1'b0;

        vec("cap",    6'b000000, 0, 0, EXE_NOP_OP,  0, 5'd5,  1, 32'hDEADBEEF, 5'd5,  1, 32'hDEADBEEF, 0, 64'h0, 64'h0, 64'h0, 64'h0);
        vec("lgdt",   6'b000000, 0, 0, EXE_LGDT_OP, 1, 5'd3,  0, 32'h11,       5'd3,  0, 32'h11,       1, 64'h0, G1,    64'h0, 64'h0);
        vec("idle",   6'b000000, 0, 0, EXE_NOP_OP,  0, 5'd0,  0, 32'h0,        5'd0,  0, 32'h0,        0, 64'h0, G1,    64'h0, 64'h0);
        vec("bubble", 6'b010000, 0, 0, EXE_LIDT_OP, 1, 5'd7,  1, 32'hCAFE,     5'd0,  0, 32'h0,        0, 64'h0, G1,    64'h0, 64'h0);
        vec("cap2",   6'b000000, 0, 0, EXE_NOP_OP,  0, 5'd9,  1, 32'h12345678, 5'd9,  1, 32'h12345678, 0, 64'h0, G1,    64'h0, 64'h0);
        vec("hold",   6'b110000, 0, 0, EXE_LLDT_OP, 1, 5'd10, 1, 32'hAAAA,     5'd9,  1, 32'h12345678, 0, 64'h0, G1,    64'h0, 64'h0);
        vec("ltr",    6'b000000, 0, 0, EXE_LTR_OP,  1, 5'd2,  1, 32'h22,       5'd2,  1, 32'h22,       1, 64'h0, G1,    64'h0, T1);
        mem_tr = T2;
        vec("hold2",  6'b110000, 0, 0, EXE_LTR_OP,  1, 5'd14, 1, 32'h77,       5'd2,  1, 32'h22,       0, 64'h0, G1,    64'h0, T1);
        vec("expfl",  6'b000000, 0, 1, EXE_LIDT_OP, 1, 5'd4,  1, 32'h44,       5'd0,  0, 32'h0,        0, 64'h0, G1,    64'h0, T1);
        vec("cap3",   6'b000000, 0, 0, EXE_NOP_OP,  0, 5'd6,  1, 32'h66,       5'd6,  1, 32'h66,       0, 64'h0, G1,    64'h0, T1);
        vec("flst",   6'b110000, 1, 0, EXE_LIDT_OP, 1, 5'd8,  1, 32'h88,       5'd0,  0, 32'h0,        0, 64'h0, G1,    64'h0, T1);
        vec("cap4",   6'b000000, 0, 0, EXE_NOP_OP,  0, 5'd15, 1, 32'h99,       5'd15, 1, 32'h99,       0, 64'h0, G1,    64'h0, T1);
        vec("flush",  6'b000000, 1, 0, EXE_LIDT_OP, 1, 5'd8,  1, 32'h88,       5'd0,  0, 32'h0,        0, 64'h0, G1,    64'h0, T1);
        vec("sidt64", 6'b000000, 0, 0, EXE_SIDT_OP, 1, 5'd11, 1, 32'hBB,       5'd11, 1, 32'hBB,       0, 64'h0, G1,    64'h0, T1);
        vec("add64",  6'b000000, 0, 0, EXE_ADD_OP,  1, 5'd12, 1, 32'hCC,       5'd12, 1, 32'hCC,       0, 64'h0, G1,    64'h0, T1);
        mem_tr = T3;
        vec("ltr3",   6'b000000, 0, 0, EXE_LTR_OP,  1, 5'd0,  0, 32'h0,        5'd0,  0, 32'h0,        1, 64'h0, G1,    64'h0, T3);
        mem_tr = T2;
        vec("str",    6'b000000, 0, 0, EXE_STR_OP,  1, 5'd13, 1, 32'hDD,       5'd13, 1, 32'hDD,       0, 64'h0, G1,    64'h0, T3);
        vec("lidt",   6'b000000, 0, 0, EXE_LIDT_OP, 1, 5'd0,  0, 32'h0,        5'd0,  0, 32'h0,        1, I1,    G1,    64'h0, T3);
        vec("lldt",   6'b000000, 0, 0, EXE_LLDT_OP, 1, 5'd1,  0, 32'h5,        5'd1,  0, 32'h5,        1, I1,    G1,    L1,    T3);
        mem_idt = T2;
        vec("lidtno", 6'b100000, 0, 0, EXE_LIDT_OP, 0, 5'd0,  0, 32'h0,        5'd0,  0, 32'h0,        0, I1,    G1,    L1,    T3);
        rst = 1'b1;
        vec("rst3",   6'b110000, 1, 0, EXE_LGDT_OP, 1, 5'd3,  1, 32'h3,        5'd0,  0, 32'h0,        0, 64'h0, 64'h0, 64'h0, 64'h0);
        rst = 1'b0;
        vec("post",   6'b000000, 0, 0, EXE_NOP_OP,  0, 5'd1,  1, 32'h1,        5'd1,  1, 32'h1,        0, 64'h0, 64'h0, 64'h0, 64'h0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
